lsu_ctrl: RTL

Load/store unit that starts data-memory accesses on behalf of the MIPS datapath. It accepts one load or store request at a time from the pipeline over a valid/ready handshake. It drives a word-wide data memory, which reads combinationally and writes synchronously. All byte handling happens here: big-endian lane selection, sign/zero extension, and read-modify-write for byte stores. It returns the result over a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_lane.sv | 26 ++
 rtl/lsu_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Covers the FSM states, the request size codes and the big-endian byte lane selects.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  // Big-endian: byte address offset 0 is the most significant byte of the word.
  function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
    case (lane)
      LANE_0:  lane_lsb = 5'd24;
      LANE_1:  lane_lsb = 5'd16;
      LANE_2:  lane_lsb = 5'd8;
      LANE_3:  lane_lsb = 5'd0;
      default: lane_lsb = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte lane logic shared by the load and store paths.
// Extracts and extends one byte of a word, and merges a byte into a word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic        i_signed,
  input  logic [31:0] i_word,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_ext,
  output logic [31:0] o_merged
);

  logic [4:0] w_lsb;
  logic [7:0] w_sel;

  assign w_lsb = lane_lsb(i_lane);
  assign w_sel = i_word[w_lsb +: 8];
  assign o_ext = {{24{i_signed & w_sel[7]}}, w_sel};

  always_comb begin
    o_merged = i_word;
    o_merged[w_lsb +: 8] = i_byte;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit for the MIPS datapath: one request at a time, byte lanes and read-modify-write.
// Defining LSU_MISALIGN_TRAP_EN turns misaligned word requests into an error response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic              i_req_size,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_e            r_state;
  state_e            w_next;
  logic              r_we;
  logic              r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wbyte;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_accept;
  logic              w_misalign;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_merged;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = (i_req_size == SIZE_WORD) && (i_req_addr[1:0] != 2'd0);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept    = (r_state == IDLE) && i_req_valid;
  assign o_req_ready = (r_state == IDLE);
  assign o_rsp_valid = (r_state == RESP);
  assign o_mem_we    = (r_state == WRITE);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;
  assign o_mem_addr  = r_addr[ADDR_W-1:2];
  assign o_mem_wdata = r_mem_wdata;

  lsu_lane u_lane (
    .i_lane   (r_addr[1:0]),
    .i_signed (r_signed),
    .i_word   (i_mem_rdata),
    .i_byte   (r_wbyte),
    .o_ext    (w_ext),
    .o_merged (w_merged)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          if (w_misalign)                             w_next = RESP;
          else if (i_req_we && i_req_size == SIZE_WORD) w_next = WRITE;
          else                                        w_next = ACCESS;
        end
      end
      ACCESS:  w_next = r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    if (i_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The result register is cleared on accept so stores and traps respond with zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we        <= 1'b0;
      r_size      <= SIZE_WORD;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wbyte     <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_we     <= i_req_we;
      r_size   <= i_req_size;
      r_signed <= i_req_signed;
      r_addr   <= i_req_addr;
      r_wbyte  <= i_req_wdata[7:0];
      r_rdata  <= '0;
      r_err    <= w_misalign;
      if (i_req_we && i_req_size == SIZE_WORD) r_mem_wdata <= i_req_wdata;
    end else if (r_state == ACCESS) begin
      if (r_we)                     r_mem_wdata <= w_merged;
      else if (r_size == SIZE_BYTE) r_rdata     <= w_ext;
      else                          r_rdata     <= i_mem_rdata;
    end
  end

endmodule
